note_period_classifier: RTL and testbench

//  Parametrised successor to the 8-note detector. Measures the full period of a 1-bit

---
 rtl/note_period_classifier.sv | 195 +++++++++++++++++++
 tb/tb_note_period_classifier.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_period_classifier.sv
// note_period_classifier: times full periods of a square wave and locks onto a table note
// after STABLE_CNT consecutive matches. `NOTE_PERIOD_OUT_EN adds period_out/period_strobe.
module note_period_classifier #(
   parameter int                          NUM_NOTES    = 8,
   parameter int                          NOTE_W       = 3,
   parameter int                          CNT_W        = 16,
   parameter logic [NUM_NOTES*CNT_W-1:0]  NOTE_PERIODS = {16'd4883, 16'd5208, 16'd5864, 16'd6510,
                                                         16'd7237, 16'd8013, 16'd8929, 16'd9766},
   parameter int                          TOL          = 100,
   parameter int                          STABLE_CNT   = 3,
   parameter int                          MAX_PERIOD   = 12000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              waveform,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic              note_change,
   output logic              silence
`ifdef NOTE_PERIOD_OUT_EN
   ,
   output logic [CNT_W-1:0]  period_out,
   output logic              period_strobe
`endif
);

   localparam int                STAGES   = 1;
   localparam logic [CNT_W-1:0]  MAX_V    = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W:0]    TOL_V    = (CNT_W+1)'(TOL);
   localparam logic [3:0]        STABLE_V = 4'(STABLE_CNT);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

   logic sync1_q, sync2_q, prev_q;
   logic rise, timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= waveform;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;

   // Rise beats timeout so a period of exactly MAX_PERIOD is still classified.
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q;
   assign timeout = (cnt_q == MAX_V) & ~rise;

   always_comb begin
      cnt_d = cnt_q;
      if (rise)
         cnt_d = CNT_W'(1);
      else if (cnt_q != MAX_V)
         cnt_d = cnt_q + CNT_W'(1);
   end

   state_t            state_q, state_d;
   logic [STAGES:0]   vld_pipe_q;
   logic              match_q;
   logic [NOTE_W-1:0] idx_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         period_q   <= '0;
         vld_pipe_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         if (rise)
            period_q <= cnt_q;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:0], rise & (state_q != IDLE)};
      end
   end

   logic [NUM_NOTES-1:0] hit_vec;
   logic [NOTE_W-1:0]    hit_idx;

   for (genvar g = 0; g < NUM_NOTES; g++) begin : g_win
      logic signed [CNT_W:0] diff;
      logic        [CNT_W:0] adiff;
      assign diff       = $signed({1'b0, period_q}) - $signed({1'b0, NOTE_PERIODS[g*CNT_W +: CNT_W]});
      assign adiff      = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
      assign hit_vec[g] = (adiff <= TOL_V);
   end

   // Descending scan so the lowest matching index wins on overlapping windows.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_NOTES-1; i >= 0; i--)
         if (hit_vec[i])
            hit_idx = NOTE_W'(i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         match_q <= |hit_vec;
         idx_q   <= hit_idx;
      end
   end

   logic [NOTE_W-1:0] cand_q, cand_d, note_q, note_d;
   logic [3:0]        run_q, run_d;
   logic              valid_q, valid_d, change_q, change_d, silence_q, silence_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cand_q    <= '0;
         run_q     <= '0;
         note_q    <= '0;
         valid_q   <= 1'b0;
         change_q  <= 1'b0;
         silence_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         run_q     <= run_d;
         note_q    <= note_d;
         valid_q   <= valid_d;
         change_q  <= change_d;
         silence_q <= silence_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      run_d     = run_q;
      note_d    = note_q;
      valid_d   = valid_q;
      change_d  = 1'b0;
      silence_d = silence_q;
      if (timeout) begin
         state_d   = IDLE;
         valid_d   = 1'b0;
         silence_d = 1'b1;
         run_d     = '0;
      end else begin
         if (rise) begin
            silence_d = 1'b0;
            if (state_q == IDLE)
               state_d = MEASURE;
         end
         if (vld_pipe_q[STAGES] && state_q != IDLE) begin
            if (!match_q)
               run_d = '0;
            else if (idx_q == cand_q)
               run_d = (run_q >= STABLE_V) ? run_q : run_q + 4'd1;
            else begin
               cand_d = idx_q;
               run_d  = 4'd1;
            end
            // While locked, a new candidate only takes over once it is itself stable.
            if (match_q && run_d >= STABLE_V) begin
               if (state_q == MEASURE) begin
                  state_d  = LOCKED;
                  note_d   = cand_d;
                  valid_d  = 1'b1;
                  change_d = 1'b1;
               end else if (cand_d != note_q) begin
                  note_d   = cand_d;
                  change_d = 1'b1;
               end
            end
         end
      end
   end

   assign note_out    = note_q;
   assign note_valid  = valid_q;
   assign note_change = change_q;
   assign silence     = silence_q;

`ifdef NOTE_PERIOD_OUT_EN
   logic strobe_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         strobe_q <= 1'b0;
      else
         strobe_q <= rise;
   end
   assign period_out    = period_q;
   assign period_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_note_period_classifier.sv
// Randomized bench for note_period_classifier; a history-based note model predicts lock,
// change pulses and silence. Table is time-scaled so the run stays short.
module tb_note_period_classifier;

   localparam int N    = 8;
   localparam int NW   = 3;
   localparam int CW   = 16;
   localparam int TOL  = 3;
   localparam int STB  = 3;
   localparam int MAXP = 240;
   localparam int PT [N] = '{195, 179, 160, 145, 130, 127, 104, 98};
   localparam logic [N*CW-1:0] TBL = {16'd98, 16'd104, 16'd127, 16'd130,
                                      16'd145, 16'd160, 16'd179, 16'd195};

   logic          clk = 1'b0;
   logic          reset;
   logic          waveform;
   logic [NW-1:0] note_out;
   logic          note_valid, note_change, silence;
`ifdef NOTE_PERIOD_OUT_EN
   logic [CW-1:0] period_out;
   logic          period_strobe;
`endif

   note_period_classifier #(
      .NUM_NOTES(N), .NOTE_W(NW), .CNT_W(CW), .NOTE_PERIODS(TBL),
      .TOL(TOL), .STABLE_CNT(STB), .MAX_PERIOD(MAXP)
   ) dut (
      .clk(clk), .reset(reset), .waveform(waveform),
      .note_out(note_out), .note_valid(note_valid),
      .note_change(note_change), .silence(silence)
`ifdef NOTE_PERIOD_OUT_EN
      , .period_out(period_out), .period_strobe(period_strobe)
`endif
   );

   always #10 clk = ~clk;

   int vecs = 0, errs = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   int chg_seen = 0, strb_seen = 0;
   always @(posedge clk) begin
      if (note_change === 1'b1) chg_seen++;
`ifdef NOTE_PERIOD_OUT_EN
      if (period_strobe === 1'b1) strb_seen++;
`endif
   end

   // Reference model: history of classified periods since the last timeout/reset.
   bit m_active, m_valid, m_sil, pout_known;
   int m_note, m_chg, m_strb, exp_pout, chg_base, strb_base;
   int hist[$];

   function automatic int classify(input int p);
      for (int i = 0; i < N; i++)
         if ((p - PT[i] <= TOL) && (PT[i] - p <= TOL)) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_active = 0; m_valid = 0; m_sil = 1; m_note = 0; m_chg = 0; m_strb = 0;
      pout_known = 0; hist.delete();
      chg_base = chg_seen; strb_base = strb_seen;
   endtask

   task automatic model_rise(input int p);
      int idx, run;
      bit had;
      had = m_active;
      m_sil = 0;
      m_strb++;
      pout_known = had;
      exp_pout = (p > MAXP) ? MAXP : p;
      if (!had || p > MAXP) begin
         if (had) m_valid = 0;
         m_active = 1;
         hist.delete();
      end else begin
         idx = classify(p);
         hist.push_back(idx);
         if (idx >= 0) begin
            run = 0;
            for (int k = hist.size() - 1; k >= 0 && hist[k] == idx; k--) run++;
            if (run >= STB && (!m_valid || m_note != idx)) begin
               m_chg++;
               m_note  = idx;
               m_valid = 1;
            end
         end
      end
   endtask

   int prev_len = 0;

   // One full input period: high h cycles, low l cycles, starting on a negedge.
   task automatic drive_period(input int h, input int l);
      waveform = 1'b1;
      model_rise(prev_len);
      prev_len = h + l;
      for (int c = 0; c < h + l; c++) begin
         if (c == h) waveform = 1'b0;
         if (c == 6) begin
            chk("note_valid", note_valid, m_valid);
            chk("note_out", note_out, m_note);
            chk("silence", silence, m_sil);
            chk("change_cnt", chg_seen - chg_base, m_chg);
`ifdef NOTE_PERIOD_OUT_EN
            chk("strobe_cnt", strb_seen - strb_base, m_strb);
            if (pout_known) chk("period_out", period_out, exp_pout);
`endif
         end
         if (c == MAXP + 8 && h + l > MAXP + 10) begin
            chk("to_silence", silence, 1);
            chk("to_valid", note_valid, 0);
            chk("to_hold", note_out, m_note);
         end
         @(negedge clk);
      end
   endtask

   task automatic drv(input int p);
      drive_period(p / 2, p - p / 2);
   endtask

   task automatic gap();
      drive_period(1, MAXP + 30);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_note_out", note_out, 0);
      chk("rst_valid", note_valid, 0);
      chk("rst_change", note_change, 0);
      chk("rst_silence", silence, 1);
      waveform = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int p, n, j, cnt, h;
      reset = 1'b1;
      waveform = 1'b0;
      model_reset();
      #45;
      chk("init_note_out", note_out, 0);
      chk("init_valid", note_valid, 0);
      chk("init_change", note_change, 0);
      chk("init_silence", silence, 1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (MAXP + 20) @(negedge clk);
      chk("idle_silence", silence, 1);
      chk("idle_valid", note_valid, 0);

      // every note from a fresh start
      for (int k = 0; k < N; k++) begin
         repeat (10) drv(PT[k]);
         gap();
      end

      // direct note switch while locked
      repeat (5) drv(130);
      repeat (5) drv(104);
      gap();

      // a single unmatched period does not drop the lock
      repeat (5) drv(160);
      drv(140);
      repeat (4) drv(160);

      // tolerance edges, overlap window, timeout boundary, glitches
      repeat (4) drv(195);
      drv(198); drv(192); drv(199); drv(191);
      repeat (4) drv(128);
      drv(MAXP);
      repeat (2) drv(128);
      drv(MAXP + 1);
      repeat (4) drv(104);
      drive_period(1, 1); drive_period(1, 2); drv(104); drv(104);
      gap();

      // reset during a partial lock
      repeat (5) drv(179);
      repeat (3) drv(145);
      reset_dut();
      prev_len = 0;

      // randomized segments
      for (int s = 0; s < 120; s++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: begin
               n   = int'($urandom_range(0, N - 1));
               cnt = int'($urandom_range(1, 6));
               for (int r = 0; r < cnt; r++) begin
                  j = int'($urandom_range(0, 2 * TOL + 2)) - (TOL + 1);
                  p = PT[n] + j;
                  h = int'($urandom_range(1, p - 1));
                  drive_period(h, p - h);
               end
            end
            7: begin
               p = int'($urandom_range(2, 60));
               h = int'($urandom_range(1, p - 1));
               drive_period(h, p - h);
            end
            8: begin
               p = int'($urandom_range(2, MAXP));
               h = int'($urandom_range(1, p - 1));
               drive_period(h, p - h);
            end
            default: begin
               if ($urandom_range(0, 3) == 0) gap();
               else drv(int'($urandom_range(MAXP - 2, MAXP + 2)));
            end
         endcase
      end
      drv(100);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
